pcd_pause_scheduler: RTL
========================

Name: pcd_pause_scheduler

Overview:
Synthesisable PCD-side modified-Miller pause scheduler. It accepts a stream of PCD bit sequences (X/Y/Z) over a valid/ready handshake and drives pcd_pause_n with tick-accurate pause placement per bit time. It enforces an inter-frame gap after each frame. It sits ahead of the carrier modulator in the PCD emulator and loopback rigs, replacing task-based pause timing with a clocked controller.

Parameters:
CNT_W, 8, width of bit_time / start-time / pause_len config inputs and of the bit and pause counters
GAP_BITS, 5, idle bit times enforced after the last sequence of a frame

Ports:
clk  in  1  carrier-rate clock, 13.56 MHz, never stops
rst  in  1  synchronous, active-high reset
seq_valid  in  1  sequence available
seq  in  2  0=ERROR, 1=X, 2=Y, 3=Z
seq_last  in  1  marks last sequence of the frame; qualified by seq_valid
seq_ready  out  1  sequence accepted on cycles where seq_valid && seq_ready
cfg_bit_time  in  CNT_W  ticks per bit (nominal 128), >=2
cfg_x_start  in  CNT_W  pause start tick for X (nominal 64), < cfg_bit_time
cfg_z_start  in  CNT_W  pause start tick for Z (nominal 0), < cfg_bit_time
cfg_pause_len  in  CNT_W  pause length in ticks (nominal 32), >=1
pcd_pause_n  out  1  active-low pause request
sending  out  1  high while frame bits are being transmitted
start_of_bit  out  1  one-cycle pulse on tick 0 of each bit time
seq_err  out  1  one-cycle pulse: ERROR sequence accepted
underrun  out  1  one-cycle pulse: next sequence missing at bit boundary

Behaviour:
- Reset: state IDLE. Outputs: pcd_pause_n=1, sending=0, seq_ready=1, start_of_bit=0, seq_err=0, underrun=0. All counters cleared. A reset mid-pause releases pcd_pause_n on the next cycle.
- States: IDLE, BIT, GAP.
- Config: cfg_* are sampled only on frame start (acceptance in IDLE) and held for the whole frame and gap.
- IDLE: seq_ready=1. On accept, latch the sequence, last flag and config. Next cycle: BIT, bit_cnt=0, sending=1.
- BIT:
  - bit_cnt increments every cycle. start_of_bit = (bit_cnt==0).
  - Pause trigger is on the cycle where bit_cnt equals the start tick for the current sequence: cfg_x_start for X, cfg_z_start for Z. Y and ERROR never trigger.
  - On trigger, pause_cnt loads cfg_pause_len. pcd_pause_n is registered low from the next cycle for exactly cfg_pause_len cycles.
  - The pause counter is independent of bit_cnt. A pause may run into the following bit time or into GAP.
  - A retrigger while a pause is active reloads pause_cnt, extending the pause; pcd_pause_n does not glitch high.
- seq_ready in BIT is high only on bit_cnt==cfg_bit_time-1 and only when the current sequence is not last.
  - Accept: latch the new sequence; bit_cnt wraps to 0. The bit period is exactly cfg_bit_time with no bubble.
  - seq_valid low at that cycle: underrun pulses and the frame terminates into GAP as if the current sequence were last.
- Last sequence: at bit_cnt==cfg_bit_time-1, go to GAP. sending drops on the first GAP cycle.
- ERROR sequence: transmitted as Y. seq_err pulses on the cycle after acceptance.
- GAP: seq_ready=0. gap_cnt counts GAP_BITS*cfg_bit_time cycles (width CNT_W+3), then IDLE. An active pause still completes during GAP.
- Sequence legality (X followed by Z, consecutive Y) is not checked; it is the upstream frame generator's responsibility.
- Counters are unsigned and never wrap within their legal config range. Out-of-range config behaviour is undefined.

Optional Feature:
PCD_PAUSE_SCHED_AUTO_SOF_EN
- Defined: on frame start the block first transmits one Z bit time (SOF) before the accepted sequence. The first accepted sequence is held and starts at the following bit boundary. sending and start_of_bit cover the SOF bit.
- Undefined: no insertion; the first accepted sequence is transmitted immediately. The upstream source must supply SOF.

Test Plan:
1. Defaults (128/64/0/32), single X with last, feature off -> pcd_pause_n low for cycles 65..96 after BIT entry; sending high 128 cycles; then 640 GAP cycles with seq_ready=0; IDLE after that.
2. Frame Z,Y,X,Z with valid held -> start_of_bit every 128 cycles with no bubble; pauses at ticks 0 / none / 64 / 0 of each bit; seq_ready accepted exactly at tick 127.
3. cfg_pause_len=80, X then Z -> pause starts tick 65 of bit 0 and, once reloaded by Z's trigger at tick 0 of bit 1, extends continuously to tick 80 of bit 1; no high glitch.
4. seq_valid dropped before second sequence -> underrun pulse at tick 127; GAP entered; sending falls; any active pause completes.
5. ERROR sequence mid-frame -> seq_err one pulse; no pause in that bit; bit timing unchanged.
6. Reset asserted during a pause at tick 70 -> next cycle pcd_pause_n=1, sending=0, seq_ready=1; a new frame is accepted normally afterwards.

Source files
------------

// File: rtl/pcd_pause_scheduler.sv
// PCD modified-Miller pause scheduler: X/Y/Z sequences in, tick-accurate pcd_pause_n out.
// Optional SOF auto-insertion when PCD_PAUSE_SCHED_AUTO_SOF_EN is defined.
module pcd_pause_scheduler #(
   parameter int CNT_W    = 8,
   parameter int GAP_BITS = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seq_valid,
   input  logic [1:0]       seq,
   input  logic             seq_last,
   output logic             seq_ready,
   input  logic [CNT_W-1:0] cfg_bit_time,
   input  logic [CNT_W-1:0] cfg_x_start,
   input  logic [CNT_W-1:0] cfg_z_start,
   input  logic [CNT_W-1:0] cfg_pause_len,
   output logic             pcd_pause_n,
   output logic             sending,
   output logic             start_of_bit,
   output logic             seq_err,
   output logic             underrun
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BIT  = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   localparam logic [1:0] SEQ_E = 2'd0;
   localparam logic [1:0] SEQ_X = 2'd1;
   localparam logic [1:0] SEQ_Z = 2'd3;

   localparam int GAP_W = CNT_W + 3;

   logic [1:0]       state;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] pause_cnt;
   logic [CNT_W-1:0] bt_q;
   logic [CNT_W-1:0] xs_q;
   logic [CNT_W-1:0] zs_q;
   logic [CNT_W-1:0] len_q;
   logic [GAP_W-1:0] gap_cnt;
   logic [GAP_W-1:0] gap_end;
   logic [1:0]       cur_seq;
   logic             cur_last;
   logic             pause_q;
   logic             err_q;
   logic             bit_end;
   logic             trigger;
   logic             accept;
   logic             hold;

`ifdef PCD_PAUSE_SCHED_AUTO_SOF_EN
   logic             sof_q;
   logic [1:0]       pend_seq;
   logic             pend_last;
   assign hold = sof_q;
`else
   assign hold = 1'b0;
`endif

   assign bit_end = (state == S_BIT) && (bit_cnt == bt_q - 1'b1);
   assign gap_end = GAP_W'(GAP_BITS) * GAP_W'(bt_q) - 1'b1;

   always_comb begin
      seq_ready = 1'b0;
      case (state)
         S_IDLE:  seq_ready = 1'b1;
         S_BIT:   seq_ready = bit_end && !cur_last && !hold;
         default: seq_ready = 1'b0;
      endcase
   end

   assign accept       = seq_valid && seq_ready;
   assign underrun     = bit_end && !cur_last && !hold && !seq_valid;
   assign trigger      = (state == S_BIT) &&
                         (((cur_seq == SEQ_X) && (bit_cnt == xs_q)) ||
                          ((cur_seq == SEQ_Z) && (bit_cnt == zs_q)));
   assign sending      = (state == S_BIT);
   assign start_of_bit = sending && (bit_cnt == '0);
   assign pcd_pause_n  = !pause_q;
   assign seq_err      = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         pause_cnt <= '0;
         pause_q   <= 1'b0;
         err_q     <= 1'b0;
         cur_seq   <= SEQ_E;
         cur_last  <= 1'b0;
         bt_q      <= '0;
         xs_q      <= '0;
         zs_q      <= '0;
         len_q     <= '0;
`ifdef PCD_PAUSE_SCHED_AUTO_SOF_EN
         sof_q     <= 1'b0;
         pend_seq  <= SEQ_E;
         pend_last <= 1'b0;
`endif
      end else begin
         err_q <= accept && (seq == SEQ_E);
         // pause runs off its own counter so it may spill into the next bit or GAP
         if (trigger) begin
            pause_q   <= 1'b1;
            pause_cnt <= len_q - 1'b1;
         end else if (pause_q) begin
            if (pause_cnt == '0) pause_q <= 1'b0;
            else pause_cnt <= pause_cnt - 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state   <= S_BIT;
                  bit_cnt <= '0;
                  bt_q    <= cfg_bit_time;
                  xs_q    <= cfg_x_start;
                  zs_q    <= cfg_z_start;
                  len_q   <= cfg_pause_len;
`ifdef PCD_PAUSE_SCHED_AUTO_SOF_EN
                  cur_seq   <= SEQ_Z;
                  cur_last  <= 1'b0;
                  pend_seq  <= seq;
                  pend_last <= seq_last;
                  sof_q     <= 1'b1;
`else
                  cur_seq  <= seq;
                  cur_last <= seq_last;
`endif
               end
            end
            S_BIT: begin
               if (!bit_end) begin
                  bit_cnt <= bit_cnt + 1'b1;
`ifdef PCD_PAUSE_SCHED_AUTO_SOF_EN
               end else if (hold) begin
                  cur_seq  <= pend_seq;
                  cur_last <= pend_last;
                  sof_q    <= 1'b0;
                  bit_cnt  <= '0;
`endif
               end else if (accept) begin
                  cur_seq  <= seq;
                  cur_last <= seq_last;
                  bit_cnt  <= '0;
               end else begin
                  state   <= S_GAP;
                  gap_cnt <= '0;
                  bit_cnt <= '0;
               end
            end
            S_GAP: begin
               if (gap_cnt == gap_end) state <= S_IDLE;
               else gap_cnt <= gap_cnt + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
